// File: rtl/coor_scanner.sv
// Raster (x, y) coordinate generator for one COLS x ROWS frame, row-major, x inner.
// Latency: first coordinate is valid one cycle after start; done pulses one cycle after the last transfer.
// Backpressure: coordinate, valid and flags hold while valid & !ready; advances only on valid & ready.
module coor_scanner #(
  parameter int COLS = 79,
  parameter int ROWS = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic       ready,
  output logic [6:0] x,
  output logic [3:0] y,
  output logic       valid,
  output logic       sof,
  output logic       eol,
  output logic       eof,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [6:0] X_LAST = 7'(COLS - 1);
  localparam logic [3:0] Y_LAST = 4'(ROWS - 1);

  state_t     state_q, state_d;
  logic [6:0] x_q, x_d;
  logic [3:0] y_q, y_d;

  logic at_x_last;
  logic at_y_last;

  assign at_x_last = (x_q == X_LAST);
  assign at_y_last = (y_q == Y_LAST);

  // State and coordinate registers; reset parks the scanner idle at (0,0).
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      x_q     <= 7'd0;
      y_q     <= 4'd0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
    end
  end

  // Next state and next coordinate: abort beats a coincident transfer, last pixel wraps to (0,0).
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SCAN;
          x_d     = 7'd0;
          y_d     = 4'd0;
        end
      end
      S_SCAN: begin
        if (abort) begin
          state_d = S_DONE;
          x_d     = 7'd0;
          y_d     = 4'd0;
        end else if (ready) begin
          if (!at_x_last) begin
            x_d = x_q + 7'd1;
          end else begin
            x_d = 7'd0;
            if (at_y_last) begin
              state_d = S_DONE;
              y_d     = 4'd0;
            end else begin
              y_d = y_q + 4'd1;
            end
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        x_d     = 7'd0;
        y_d     = 4'd0;
      end
    endcase
  end

  // Outputs decoded from registered state and coordinate; frame flags are qualified by valid.
  always_comb begin
    valid = (state_q == S_SCAN);
    busy  = (state_q != S_IDLE);
    done  = (state_q == S_DONE);
    x     = x_q;
    y     = y_q;
    sof   = valid && (x_q == 7'd0) && (y_q == 4'd0);
    eol   = valid && at_x_last;
    eof   = valid && at_x_last && at_y_last;
  end

endmodule

// File: tb/tb_coor_scanner.sv
// Bench for coor_scanner: a 79x16 instance and a 3x2 instance, each tracked by a pixel-index model.
// Every cycle both instances are compared against the model; directed literals pin key points.
// Inputs change only after the falling-edge comparison, so they are stable at each rising edge.
module tb_coor_scanner;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rs[2], st[2], ab[2], rd[2];
  logic [6:0] dx[2];
  logic [3:0] dy[2];
  logic       dv[2], dsof[2], deol[2], deof[2], dbusy[2], ddone[2];

  coor_scanner #(.COLS(79), .ROWS(16)) u_big (
    .clk(clk), .rst(rs[0]), .start(st[0]), .abort(ab[0]), .ready(rd[0]),
    .x(dx[0]), .y(dy[0]), .valid(dv[0]), .sof(dsof[0]), .eol(deol[0]),
    .eof(deof[0]), .busy(dbusy[0]), .done(ddone[0])
  );

  coor_scanner #(.COLS(3), .ROWS(2)) u_small (
    .clk(clk), .rst(rs[1]), .start(st[1]), .abort(ab[1]), .ready(rd[1]),
    .x(dx[1]), .y(dy[1]), .valid(dv[1]), .sof(dsof[1]), .eol(deol[1]),
    .eof(deof[1]), .busy(dbusy[1]), .done(ddone[1])
  );

  int n_cmp = 0;
  int n_fail = 0;

  // model: phase 0 idle, 1 scanning pixel m_k, 2 done
  int m_ph[2];
  int m_k[2];

  // scoreboard statistics
  int          n_xfer[2], n_eol[2], n_eof[2], n_done[2], sb_k[2];
  logic [10:0] eofxy[2];
  logic [10:0] small_seq[$];

  function automatic int cols(int i);
    return (i == 0) ? 79 : 3;
  endfunction

  function automatic int rows(int i);
    return (i == 0) ? 16 : 2;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // expected {x, y, valid, sof, eol, eof, busy, done}
  function automatic logic [16:0] exp_vec(int i);
    int c, k;
    logic v;
    logic [6:0] ex;
    logic [3:0] ey;
    c  = cols(i);
    k  = m_k[i];
    v  = (m_ph[i] == 1);
    ex = v ? 7'(k % c) : 7'd0;
    ey = v ? 4'(k / c) : 4'd0;
    return {ex, ey, v, v && (k == 0), v && ((k % c) == c - 1),
            v && (k == c * rows(i) - 1), m_ph[i] != 0, m_ph[i] == 2};
  endfunction

  task automatic model_update();
    for (int i = 0; i < 2; i++) begin
      if (rs[i]) begin
        m_ph[i] = 0;
        m_k[i]  = 0;
      end else begin
        case (m_ph[i])
          0: if (st[i]) begin m_ph[i] = 1; m_k[i] = 0; end
          1: begin
            if (ab[i]) begin
              m_ph[i] = 2;
              m_k[i]  = 0;
            end else if (rd[i]) begin
              m_k[i]++;
              if (m_k[i] == cols(i) * rows(i)) begin
                m_ph[i] = 2;
                m_k[i]  = 0;
              end
            end
          end
          default: m_ph[i] = 0;
        endcase
      end
    end
  endtask

  task automatic record(int i);
    int c;
    c = cols(i);
    n_xfer[i]++;
    if (deol[i]) n_eol[i]++;
    if (deof[i]) begin
      n_eof[i]++;
      eofxy[i] = {dx[i], dy[i]};
    end
    chk($sformatf("raster%0d", i), {dx[i], dy[i]}, {7'(sb_k[i] % c), 4'(sb_k[i] / c)});
    sb_k[i]++;
    if (sb_k[i] == c * rows(i)) sb_k[i] = 0;
    if (i == 1) small_seq.push_back({dx[1], dy[1]});
  endtask

  task automatic clr(int i);
    n_xfer[i] = 0; n_eol[i] = 0; n_eof[i] = 0; n_done[i] = 0; sb_k[i] = 0;
    eofxy[i] = 11'd0;
  endtask

  // one clock: log transfers, advance model on the edge, compare on the falling edge
  task automatic step();
    logic        stall[2];
    logic [10:0] held[2];
    for (int i = 0; i < 2; i++) begin
      if (dv[i] === 1'b1 && rd[i]) record(i);
      stall[i] = (dv[i] === 1'b1) && !rd[i] && !rs[i] && !ab[i];
      held[i]  = {dx[i], dy[i]};
    end
    @(posedge clk);
    model_update();
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("model%0d", i),
          {dx[i], dy[i], dv[i], dsof[i], deol[i], deof[i], dbusy[i], ddone[i]}, exp_vec(i));
      if (ddone[i] === 1'b1) n_done[i]++;
      if (stall[i]) chk($sformatf("stall_hold%0d", i), {dv[i], dx[i], dy[i]}, {1'b1, held[i]});
    end
  endtask

  task automatic run_to(int i, int tx, int ty);
    int n;
    n = 0;
    rd[i] = 1'b1;
    while (!(dv[i] === 1'b1 && dx[i] == 7'(tx) && dy[i] == 4'(ty)) && n < 3000) begin
      step();
      n++;
    end
    chk("reach_xy", {dv[i], dx[i], dy[i]}, {1'b1, 7'(tx), 4'(ty)});
  endtask

  task automatic run_done(int i, int budget, logic rand_ready);
    int n;
    n = 0;
    while (ddone[i] !== 1'b1 && n < budget) begin
      rd[i] = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      step();
      n++;
    end
    chk("done_seen", ddone[i], 1);
  endtask

  task automatic start_frame(int i);
    st[i] = 1'b1;
    step();
    st[i] = 1'b0;
  endtask

  logic [10:0] tbl[6];

  initial begin
    for (int i = 0; i < 2; i++) begin
      rs[i] = 1'b1; st[i] = 1'b0; ab[i] = 1'b0; rd[i] = 1'b0;
      m_ph[i] = 0; m_k[i] = 0;
      clr(i);
    end
    step();
    step();
    rs[0] = 1'b0;
    rs[1] = 1'b0;

    // reset state
    chk("rst_valid", dv[0], 0);
    chk("rst_busy", dbusy[0], 0);
    chk("rst_done", ddone[0], 0);
    chk("rst_xy", {dx[0], dy[0]}, 0);
    chk("rst_flags", {dsof[0], deol[0], deof[0]}, 0);
    chk("rst_small", {dv[1], dbusy[1], ddone[1], dx[1], dy[1]}, 0);

    // full frame, ready high
    clr(0);
    rd[0] = 1'b1;
    start_frame(0);
    chk("first_valid", {dv[0], dsof[0], dbusy[0], dx[0], dy[0]}, {3'b111, 11'd0});
    run_done(0, 1400, 1'b0);
    chk("full_xfers", n_xfer[0], 1264);
    chk("full_eol", n_eol[0], 16);
    chk("full_eof", n_eof[0], 1);
    chk("full_eof_xy", eofxy[0], {7'd78, 4'd15});
    chk("full_done_cnt", n_done[0], 1);
    chk("done_busy", {dbusy[0], dv[0]}, 2'b10);
    rd[0] = 1'b0;
    step();
    chk("busy_fall", {dbusy[0], ddone[0]}, 0);

    // random back-pressure
    clr(0);
    start_frame(0);
    run_done(0, 6000, 1'b1);
    chk("bp_xfers", n_xfer[0], 1264);
    chk("bp_eof", n_eof[0], 1);
    rd[0] = 1'b0;
    step();

    // line wrap stall, ignored start, mid-frame reset
    clr(0);
    start_frame(0);
    run_to(0, 78, 3);
    rd[0] = 1'b0;
    repeat (5) begin
      step();
      chk("wrap_eol", {dv[0], deol[0], dx[0], dy[0]}, {2'b11, 7'd78, 4'd3});
    end
    rd[0] = 1'b1;
    step();
    chk("wrap_next", {dv[0], deol[0], dx[0], dy[0]}, {2'b10, 7'd0, 4'd4});
    run_to(0, 40, 7);
    st[0] = 1'b1;
    step();
    st[0] = 1'b0;
    chk("ign_start", {dv[0], dx[0], dy[0]}, {1'b1, 7'd41, 4'd7});
    run_to(0, 5, 9);
    rs[0] = 1'b1;
    step();
    rs[0] = 1'b0;
    rd[0] = 1'b0;
    chk("mid_rst", {dv[0], dbusy[0], ddone[0], dx[0], dy[0]}, 0);
    repeat (3) step();
    chk("no_done_after_rst", n_done[0], 0);

    // abort with ready high
    clr(0);
    start_frame(0);
    run_to(0, 10, 2);
    ab[0] = 1'b1;
    step();
    ab[0] = 1'b0;
    rd[0] = 1'b0;
    chk("abort", {dv[0], ddone[0], dbusy[0], dx[0], dy[0]}, {3'b011, 11'd0});
    step();
    chk("abort_idle", {dbusy[0], ddone[0], dv[0]}, 0);
    ab[0] = 1'b1;
    step();
    ab[0] = 1'b0;
    chk("abort_in_idle", {dbusy[0], ddone[0], dv[0]}, 0);
    clr(0);
    start_frame(0);
    chk("restart", {dv[0], dsof[0], dx[0], dy[0]}, {2'b11, 11'd0});
    ab[0] = 1'b1;
    step();
    ab[0] = 1'b0;
    step();

    // small geometry 3x2
    tbl[0] = {7'd0, 4'd0}; tbl[1] = {7'd1, 4'd0}; tbl[2] = {7'd2, 4'd0};
    tbl[3] = {7'd0, 4'd1}; tbl[4] = {7'd1, 4'd1}; tbl[5] = {7'd2, 4'd1};
    clr(1);
    small_seq.delete();
    rd[1] = 1'b1;
    start_frame(1);
    run_done(1, 50, 1'b0);
    chk("small_xfers", n_xfer[1], 6);
    for (int j = 0; j < small_seq.size() && j < 6; j++)
      chk($sformatf("small_seq%0d", j), small_seq[j], tbl[j]);
    chk("small_eof", n_eof[1], 1);
    chk("small_eof_xy", eofxy[1], {7'd2, 4'd1});
    chk("small_eol", n_eol[1], 2);
    rd[1] = 1'b0;
    step();
    chk("small_idle", {dbusy[1], ddone[1]}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
